// File: rtl/deque_ctrl_if.sv
// -----------------------------------------------------------------------------
// deque_ctrl_if
// Request/response bundle for the deque controller.
//   master : drives clear, push_back, push_front, pop_front, pop_back, din
//            and observes front_data, back_data, count, full, empty, err
//   slave  : the mirror image, used by deque_ctrl
// Parameters DATA_W / DEPTH must match the deque_ctrl instance they attach to.
// -----------------------------------------------------------------------------
interface deque_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              clear;
    logic              push_back;
    logic              push_front;
    logic              pop_front;
    logic              pop_back;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] front_data;
    logic [DATA_W-1:0] back_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [2:0]        err;

    modport master (
        output clear, push_back, push_front, pop_front, pop_back, din,
        input  front_data, back_data, count, full, empty, err
    );

    modport slave (
        input  clear, push_back, push_front, pop_front, pop_back, din,
        output front_data, back_data, count, full, empty, err
    );
endinterface

// File: rtl/deque_ctrl.sv
// -----------------------------------------------------------------------------
// deque_ctrl
// Double-ended queue held in a circular buffer. head points at the front
// element, tail at the slot after the back element; both wrap modulo DEPTH.
// One operation per cycle, priority clear > push_back > push_front >
// pop_front > pop_back. err is sticky: [0] overflow, [1] underflow,
// [2] collision (more than one request in a cycle); clear empties the deque
// and clears err.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : deque_ctrl_if.slave (requests, din, front/back data, count,
//            full, empty, err)
// Optional feature: define DEQUE_CTRL_STATS_EN to add push_total / pop_total
// (16-bit saturating counts of accepted pushes / pops, reset only by rst_n).
// -----------------------------------------------------------------------------
module deque_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    deque_ctrl_if.slave   bus
`ifdef DEQUE_CTRL_STATS_EN
    ,
    output logic [15:0]   push_total,
    output logic [15:0]   pop_total
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointer arithmetic relies on DEPTH being a power of two: the natural
    // AW-bit overflow gives the modulo-DEPTH wrap in both directions.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p + AW'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return p - AW'(1);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        err_q, err_d;

    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s;
    logic              push_acc_s;
    logic              pop_acc_s;
    logic [4:0]        req_vec_s;
    logic              multi_s;
    logic              full_s;
    logic              empty_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_s   = (count_q == {CW{1'b0}});
    assign req_vec_s = {bus.clear, bus.push_back, bus.push_front,
                        bus.pop_front, bus.pop_back};
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_s   = ((req_vec_s & (req_vec_s - 5'd1)) != 5'd0);

    // Next-state decode: pick the single winning request and apply it.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        err_d      = err_q;
        wr_en_s    = 1'b0;
        wr_addr_s  = tail_q;
        push_acc_s = 1'b0;
        pop_acc_s  = 1'b0;

        if (bus.clear) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
            err_d   = 3'b000;
        end else begin
            if (bus.push_back) begin
                if (full_s) begin
                    err_d[0] = 1'b1;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_addr_s  = tail_q;
                    tail_d     = ptr_inc(tail_q);
                    count_d    = count_q + CW'(1);
                    push_acc_s = 1'b1;
                end
            end else if (bus.push_front) begin
                if (full_s) begin
                    err_d[0] = 1'b1;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_addr_s  = ptr_dec(head_q);
                    head_d     = ptr_dec(head_q);
                    count_d    = count_q + CW'(1);
                    push_acc_s = 1'b1;
                end
            end else if (bus.pop_front) begin
                if (empty_s) begin
                    err_d[1] = 1'b1;
                end else begin
                    head_d    = ptr_inc(head_q);
                    count_d   = count_q - CW'(1);
                    pop_acc_s = 1'b1;
                end
            end else if (bus.pop_back) begin
                if (empty_s) begin
                    err_d[1] = 1'b1;
                end else begin
                    tail_d    = ptr_dec(tail_q);
                    count_d   = count_q - CW'(1);
                    pop_acc_s = 1'b1;
                end
            end else begin
                err_d = err_q;
            end

            if (multi_s) begin
                err_d[2] = 1'b1;
            end else begin
                err_d[2] = err_d[2];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            err_q   <= 3'b000;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage array; unreset because empty slots are never shown on outputs.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= bus.din;
        end
    end

    // Zero-latency output decode of the registered state.
    always_comb begin
        if (empty_s) begin
            bus.front_data = {DATA_W{1'b0}};
            bus.back_data  = {DATA_W{1'b0}};
        end else begin
            bus.front_data = mem_q[head_q];
            bus.back_data  = mem_q[ptr_dec(tail_q)];
        end
    end

    assign bus.count = count_q;
    assign bus.full  = full_s;
    assign bus.empty = empty_s;
    assign bus.err   = err_q;

`ifdef DEQUE_CTRL_STATS_EN
    logic [15:0] push_total_q, push_total_d;
    logic [15:0] pop_total_q, pop_total_d;

    // Saturating accepted-operation counters; deliberately untouched by clear.
    always_comb begin
        push_total_d = push_total_q;
        pop_total_d  = pop_total_q;
        if (push_acc_s && (push_total_q != 16'hFFFF)) begin
            push_total_d = push_total_q + 16'd1;
        end else begin
            push_total_d = push_total_q;
        end
        if (pop_acc_s && (pop_total_q != 16'hFFFF)) begin
            pop_total_d = pop_total_q + 16'd1;
        end else begin
            pop_total_d = pop_total_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_total_q <= 16'd0;
            pop_total_q  <= 16'd0;
        end else begin
            push_total_q <= push_total_d;
            pop_total_q  <= pop_total_d;
        end
    end

    assign push_total = push_total_q;
    assign pop_total  = pop_total_q;
`else
    logic unused_acc_s;
    assign unused_acc_s = push_acc_s ^ pop_acc_s;
`endif

endmodule

// File: tb/tb_deque_ctrl.sv
// -----------------------------------------------------------------------------
// tb_deque_ctrl
// Directed and randomized checks of deque_ctrl (DEPTH=4) against a queue-based
// reference model of the deque rules.
// -----------------------------------------------------------------------------
module tb_deque_ctrl;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    deque_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef DEQUE_CTRL_STATS_EN
    logic [15:0] push_total;
    logic [15:0] pop_total;
`endif

    deque_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DEQUE_CTRL_STATS_EN
        ,
        .push_total (push_total),
        .pop_total  (pop_total)
`endif
    );

    // Reference model
    logic [DATA_W-1:0] mq [$];
    logic [2:0]        m_err;
    int                m_push;
    int                m_pop;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_err  = 3'b000;
        m_push = 0;
        m_pop  = 0;
    endtask

    // req = {clear, push_back, push_front, pop_front, pop_back}
    task automatic model_step(input logic [4:0] req, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) if (req[i]) n++;
        if (req[4]) begin
            mq.delete();
            m_err = 3'b000;
        end else begin
            if (req[3]) begin
                if (mq.size() == DEPTH) m_err[0] = 1'b1;
                else begin mq.push_back(d); m_push++; end
            end else if (req[2]) begin
                if (mq.size() == DEPTH) m_err[0] = 1'b1;
                else begin mq.push_front(d); m_push++; end
            end else if (req[1]) begin
                if (mq.size() == 0) m_err[1] = 1'b1;
                else begin void'(mq.pop_front()); m_pop++; end
            end else if (req[0]) begin
                if (mq.size() == 0) m_err[1] = 1'b1;
                else begin void'(mq.pop_back()); m_pop++; end
            end
            if (n > 1) m_err[2] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] ef, eb;
        ef = (mq.size() != 0) ? mq[0] : '0;
        eb = (mq.size() != 0) ? mq[mq.size()-1] : '0;
        check({tag, "_front"}, 32'(bus.front_data), 32'(ef));
        check({tag, "_back"},  32'(bus.back_data),  32'(eb));
        check({tag, "_count"}, 32'(bus.count),      32'(mq.size()));
        check({tag, "_full"},  32'(bus.full),       32'(mq.size() == DEPTH));
        check({tag, "_empty"}, 32'(bus.empty),      32'(mq.size() == 0));
        check({tag, "_err"},   32'(bus.err),        32'(m_err));
`ifdef DEQUE_CTRL_STATS_EN
        check({tag, "_pusht"}, 32'(push_total), 32'(m_push));
        check({tag, "_popt"},  32'(pop_total),  32'(m_pop));
`endif
    endtask

    task automatic drive(input logic [4:0] req, input logic [DATA_W-1:0] d);
        bus.clear      = req[4];
        bus.push_back  = req[3];
        bus.push_front = req[2];
        bus.pop_front  = req[1];
        bus.pop_back   = req[0];
        bus.din        = d;
    endtask

    // Apply one request for one clock, update the model, check #1 after the edge.
    task automatic do_op(input string tag, input logic [4:0] req, input logic [DATA_W-1:0] d);
        drive(req, d);
        @(posedge clk);
        model_step(req, d);
        #1;
        drive(5'b00000, 8'h00);
        check_all(tag);
    endtask

    localparam logic [4:0] OP_CLR = 5'b10000;
    localparam logic [4:0] OP_PB  = 5'b01000;
    localparam logic [4:0] OP_PF  = 5'b00100;
    localparam logic [4:0] OP_POF = 5'b00010;
    localparam logic [4:0] OP_POB = 5'b00001;

    initial begin
        logic [4:0] req;
        int         r;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b0;
        drive(5'b00000, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_idle");

        // Three push_backs
        do_op("pb1", OP_PB, 8'h11);
        check("single_front_eq_back", 32'(bus.front_data), 32'(bus.back_data));
        do_op("pb2", OP_PB, 8'h22);
        do_op("pb3", OP_PB, 8'h33);
        check("d033_count", 32'(bus.count), 32'd3);
        check("d033_front", 32'(bus.front_data), 32'h11);
        check("d033_back",  32'(bus.back_data),  32'h33);

        // Two push_fronts from empty: head wraps 0 -> 3 -> 2
        do_op("clr1", OP_CLR, 8'h00);
        do_op("pf1", OP_PF, 8'hA0);
        do_op("pf2", OP_PF, 8'hB0);
        check("d034_front", 32'(bus.front_data), 32'hB0);
        check("d034_back",  32'(bus.back_data),  32'hA0);

        // Fill, then overflow
        do_op("pb4", OP_PB, 8'hC1);
        do_op("pb5", OP_PB, 8'hC2);
        do_op("ovf", OP_PB, 8'h55);
        check("d035_full", 32'(bus.full), 32'd1);
        check("d035_err",  32'(bus.err),  32'b001);
        check("d035_back", 32'(bus.back_data), 32'hC2);
        do_op("ovf_pf", OP_PF, 8'h66);

        // Drain from both ends across the wrap point, then underflow
        do_op("pob1", OP_POB, 8'h00);
        do_op("pof1", OP_POF, 8'h00);
        do_op("pof2", OP_POF, 8'h00);
        do_op("pob2", OP_POB, 8'h00);
        do_op("clr2", OP_CLR, 8'h00);
        do_op("unf", OP_POF, 8'h00);
        check("d036_err", 32'(bus.err), 32'b010);
        do_op("unf_b", OP_POB, 8'h00);
        do_op("clr3", OP_CLR, 8'h00);
        check("d036_err_clr", 32'(bus.err), 32'b000);

        // Collision: push_back wins over pop_front on empty deque
        do_op("coll", OP_PB | OP_POF, 8'h77);
        check("d037_count", 32'(bus.count), 32'd1);
        check("d037_err",   32'(bus.err),   32'b100);
        check("d037_front", 32'(bus.front_data), 32'h77);
        do_op("coll2", OP_PF | OP_POB, 8'h78);
        do_op("clr4", OP_CLR | OP_PB, 8'h79);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       req = OP_CLR;
            else if (r < 10) req = 5'($urandom_range(0, 31));
            else if (r < 35) req = OP_PB;
            else if (r < 55) req = OP_PF;
            else if (r < 78) req = OP_POF;
            else             req = OP_POB;
            do_op("rand", req, 8'($urandom));
        end

        // Statistics then reset during a push
        do_op("clr5", OP_CLR, 8'h00);
        model_reset();
        rst_n = 1'b0;
        #1;
        check_all("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("s_pb1", OP_PB, 8'h01);
        do_op("s_pb2", OP_PB, 8'h02);
        do_op("s_pf3", OP_PF, 8'h03);
        do_op("s_pof", OP_POF, 8'h00);
        do_op("s_pob", OP_POB, 8'h00);
`ifdef DEQUE_CTRL_STATS_EN
        check("d038_push_pre", 32'(push_total), 32'd3);
        check("d038_pop_pre",  32'(pop_total),  32'd2);
`endif
        drive(OP_PB, 8'hEE);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        drive(5'b00000, 8'h00);
        @(posedge clk);
        #1;
        check_all("in_reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("first_after_rst", OP_PB, 8'h5A);
        check("first_after_rst_front", 32'(bus.front_data), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/deque_ctrl.md
DEQUE_CTRL -- requirements
Module: deque_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each stored element.
REQ-002 SHALL have parameter DEPTH, default 8, element capacity; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port clear  input  1  empties the deque in one cycle.
REQ-006 SHALL have port push_back  input  1  appends din at the back.
REQ-007 SHALL have port push_front  input  1  prepends din at the front.
REQ-008 SHALL have port pop_front  input  1  removes the front element.
REQ-009 SHALL have port pop_back  input  1  removes the back element.
REQ-010 SHALL have port din  input  DATA_W  write data for either push.
REQ-011 SHALL have port front_data  output  DATA_W  current front element; 0 when empty.
REQ-012 SHALL have port back_data  output  DATA_W  current back element; 0 when empty.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored elements.
REQ-014 SHALL have port full, output, 1, count==DEPTH; and port empty, output, 1, count==0.
REQ-015 SHALL have port err  output  3  sticky flags: [0] overflow, [1] underflow, [2] collision.

Function
REQ-016 SHALL store elements in a circular buffer using head (front) and tail (next back slot) pointers that wrap modulo DEPTH.
REQ-017 SHALL execute at most one operation per cycle, priority clear > push_back > push_front > pop_front > pop_back.
REQ-018 SHALL set err[2] when more than one request is high in a cycle; the lower-priority requests are dropped.
REQ-019 push_back: mem[tail]<=din, tail<=tail+1, count+1; visible on back_data the next cycle.
REQ-020 push_front: head<=head-1, mem[head-1]<=din, count+1; visible on front_data the next cycle.
REQ-021 pop_front: head<=head+1, count-1. pop_back: tail<=tail-1, count-1.
REQ-022 A push when full SHALL be ignored (no state change) and SHALL set err[0].
REQ-023 A pop when empty SHALL be ignored and SHALL set err[1].
REQ-024 clear SHALL set head=tail=count=0 the next cycle and SHALL also clear err.
REQ-025 front_data/back_data/full/empty SHALL be combinational decodes of registered state (zero-latency read, one-cycle update latency).
REQ-026 Pointer decrement from 0 SHALL wrap to DEPTH-1; increment from DEPTH-1 SHALL wrap to 0.
REQ-027 With a single element, front_data SHALL equal back_data.

Reset
REQ-028 On rst_n low, asynchronously: head=0, tail=0, count=0, empty=1, full=0, err=0, front_data=back_data=0.
REQ-029 Storage array contents SHALL NOT require reset; outputs never expose unwritten slots.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight request; the first operation is accepted on the first rising edge with rst_n high.

Configuration
REQ-031 Macro DEQUE_CTRL_STATS_EN: when defined, adds outputs push_total and pop_total (16 bits each), counting accepted pushes/pops, saturating at 0xFFFF, reset to 0, not cleared by clear.
REQ-032 Without DEQUE_CTRL_STATS_EN the counter ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 DEPTH=4: push_back 0x11,0x22,0x33 -> count=3, front_data=0x11, back_data=0x33.
REQ-034 From empty, push_front 0xA0, then push_front 0xB0 (head wraps 0->3->2) -> front_data=0xB0, back_data=0xA0.
REQ-035 Fill 4 elements, then push_back 0x55 -> count stays 4, full=1, err=3'b001, back_data unchanged.
REQ-036 Empty, pop_front -> err=3'b010; then clear -> err=0, count=0.
REQ-037 push_back 0x77 together with pop_front on an empty deque -> push accepted, count=1, err=3'b100.
REQ-038 With stats enabled: 3 pushes and 2 pops, then rst_n low mid-push -> counters read 3/2 before reset and 0/0 after, count=0.
